// File: rtl/ex_stage_md_if.sv
// Operand, control and result bundle between the decode/issue logic and ex_stage_md.
interface ex_stage_md_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FWD_SRCS = 5,
    parameter int unsigned SELW     = 3
);
    logic [WIDTH-1:0]          rd1;
    logic [WIDTH-1:0]          rd2;
    logic [WIDTH-1:0]          ext_imm;
    logic [WIDTH*FWD_SRCS-1:0] fwd_bus;
    logic [SELW-1:0]           fwd_a_sel;
    logic [SELW-1:0]           fwd_b_sel;
    logic                      alu_src;
    logic [3:0]                alu_ctr;
    logic [1:0]                res_sel;
    logic                      md_start;
    logic [1:0]                md_op;
    logic [WIDTH-1:0]          ex_res;
    logic [WIDTH-1:0]          fwd_b;
    logic                      md_busy;
    logic                      md_done;
    logic                      stall;

    modport master (
        output rd1, rd2, ext_imm, fwd_bus, fwd_a_sel, fwd_b_sel,
               alu_src, alu_ctr, res_sel, md_start, md_op,
        input  ex_res, fwd_b, md_busy, md_done, stall
    );

    modport slave (
        input  rd1, rd2, ext_imm, fwd_bus, fwd_a_sel, fwd_b_sel,
               alu_src, alu_ctr, res_sel, md_start, md_op,
        output ex_res, fwd_b, md_busy, md_done, stall
    );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU and, when EX_STAGE_MD_EN is
// defined, a one-bit-per-cycle multiply/divide unit with HI/LO registers.
module ex_stage_md #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FWD_SRCS = 5,
    parameter int unsigned SELW     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_stage_md_if.slave bus
);
    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_bv;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] hi_c;
    logic [WIDTH-1:0] lo_c;
    logic [WIDTH-1:0] ex_res_c;
    logic [SHW-1:0]   shamt;

    // Operand select: 0 = register file, k = forwarding source k-1, anything else = 0
    always_comb begin
        fwd_a  = '0;
        fwd_bv = '0;
        if (bus.fwd_a_sel == '0) fwd_a  = bus.rd1;
        if (bus.fwd_b_sel == '0) fwd_bv = bus.rd2;
        for (int unsigned k = 0; k < FWD_SRCS; k++) begin
            if (bus.fwd_a_sel == SELW'(k + 1)) fwd_a  = bus.fwd_bus[k*WIDTH +: WIDTH];
            if (bus.fwd_b_sel == SELW'(k + 1)) fwd_bv = bus.fwd_bus[k*WIDTH +: WIDTH];
        end
    end

    assign alu_b     = bus.alu_src ? bus.ext_imm : fwd_bv;
    assign shamt     = fwd_a[SHW-1:0];
    assign bus.fwd_b = fwd_bv;

    always_comb begin
        alu_res = '0;
        case (bus.alu_ctr)
            4'd0:    alu_res = fwd_a + alu_b;
            4'd1:    alu_res = fwd_a - alu_b;
            4'd2:    alu_res = fwd_a & alu_b;
            4'd3:    alu_res = fwd_a | alu_b;
            4'd4:    alu_res = fwd_a ^ alu_b;
            4'd5:    alu_res = ~(fwd_a | alu_b);
            4'd6:    alu_res = WIDTH'($signed(fwd_a) < $signed(alu_b));
            4'd7:    alu_res = WIDTH'(fwd_a < alu_b);
            4'd8:    alu_res = alu_b << shamt;
            4'd9:    alu_res = alu_b >> shamt;
            4'd10:   alu_res = WIDTH'($signed(alu_b) >>> shamt);
            4'd11:   alu_res = alu_b << (WIDTH / 2);
            default: alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_MD_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               busy;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;

    // Iterate on magnitudes; signs are applied once in the FIX cycle
    assign op_signed = bus.md_op[0];
    assign a_mag     = (op_signed && fwd_a[WIDTH-1])  ? -fwd_a  : fwd_a;
    assign b_mag     = (op_signed && fwd_bv[WIDTH-1]) ? -fwd_bv : fwd_bv;

    // acc = {partial product high, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd_q};
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.md_start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    div_d    = bus.md_op[1];
                    a_raw_d  = fwd_a;
                    neg_lo_d = op_signed & (fwd_a[WIDTH-1] ^ fwd_bv[WIDTH-1]);
                    neg_hi_d = op_signed & fwd_a[WIDTH-1];
                    div0_d   = bus.md_op[1] & (fwd_bv == '0);
                    if (bus.md_op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            S_RUN: begin
                if (div_q) begin
                    acc_d = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign hi_c        = hi_q;
    assign lo_c        = lo_q;
    assign bus.md_busy = busy;
    assign bus.md_done = done_q;
    assign bus.stall   = busy & (bus.md_start | (bus.res_sel == 2'd1) | (bus.res_sel == 2'd2));
`else
    logic unused_md;
    assign unused_md   = ^{clk, rst_n, bus.md_start, bus.md_op};
    assign hi_c        = '0;
    assign lo_c        = '0;
    assign bus.md_busy = 1'b0;
    assign bus.md_done = 1'b0;
    assign bus.stall   = 1'b0;
`endif

    always_comb begin
        ex_res_c = '0;
        case (bus.res_sel)
            2'd0:    ex_res_c = alu_res;
            2'd1:    ex_res_c = hi_c;
            2'd2:    ex_res_c = lo_c;
            default: ex_res_c = '0;
        endcase
    end

    assign bus.ex_res = ex_res_c;
endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized self-checking bench for ex_stage_md against an arithmetic reference model.
module tb_ex_stage_md;
    localparam int unsigned W    = 32;
    localparam int unsigned NS   = 5;
    localparam int unsigned SW   = 3;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] src [NS];

    always #5 clk = ~clk;

    ex_stage_md_if #(.WIDTH(W), .FWD_SRCS(NS), .SELW(SW)) bus ();

    ex_stage_md #(.WIDTH(W), .FWD_SRCS(NS), .SELW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] pick(input logic [2:0] sel, input logic [31:0] regv);
        if (sel == 3'd0) return regv;
        if (sel <= NS) return src[sel - 3'd1];
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] ctr);
        int sh;
        sh = int'(a % 32);
        case (ctr)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   return b[31] ? ~((~b) >> sh) : (b >> sh);
            4'd11:   return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_md(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo);
        logic [63:0] up;
        longint      sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin up = 64'(a) * 64'(b); {hi, lo} = up; end
            2'd1: begin p = sa * sb; {hi, lo} = p; end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 2'd2) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MINV;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic load_srcs();
        for (int k = 0; k < NS; k++) bus.fwd_bus[k*W +: W] = src[k];
    endtask

    task automatic idle_inputs();
        bus.rd1 = '0; bus.rd2 = '0; bus.ext_imm = '0; bus.fwd_bus = '0;
        bus.fwd_a_sel = '0; bus.fwd_b_sel = '0; bus.alu_src = 1'b0;
        bus.alu_ctr = '0; bus.res_sel = '0; bus.md_start = 1'b0; bus.md_op = '0;
        for (int k = 0; k < NS; k++) src[k] = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.md_start = 1'b1; bus.res_sel = 2'd1;
        #3;
        checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", bus.md_busy); end
        checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", bus.md_done); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", bus.stall); end
        checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", bus.ex_res); end
        bus.res_sel = 2'd2; #1;
        checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", bus.ex_res); end
        bus.md_start = 1'b0; bus.res_sel = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_alu();
        logic [31:0] ea, eb, er;
        idle_inputs();
        src[2] = 32'h1234_5678; load_srcs();
        bus.rd2 = 32'd1; bus.fwd_a_sel = 3'd3; bus.alu_ctr = 4'd0;
        #1;
        checks++; if (bus.ex_res !== 32'h1234_5679) begin failures++; $display("FAIL fwd_src2_add got=%h want=12345679", bus.ex_res); end
        checks++; if (bus.fwd_b !== 32'd1) begin failures++; $display("FAIL fwd_b_reg got=%h want=1", bus.fwd_b); end
        bus.fwd_a_sel = 3'd7; #1;
        checks++; if (bus.ex_res !== 32'd1) begin failures++; $display("FAIL fwd_sel7_zero got=%h want=1", bus.ex_res); end
        bus.fwd_a_sel = 3'd6; #1;
        checks++; if (bus.ex_res !== 32'd1) begin failures++; $display("FAIL fwd_sel6_zero got=%h want=1", bus.ex_res); end
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < NS; k++) src[k] = $urandom;
            load_srcs();
            bus.rd1 = $urandom; bus.rd2 = $urandom; bus.ext_imm = $urandom;
            bus.fwd_a_sel = 3'($urandom_range(0, 7));
            bus.fwd_b_sel = 3'($urandom_range(0, 7));
            bus.alu_src = 1'($urandom_range(0, 1));
            bus.alu_ctr = 4'($urandom_range(0, 15));
            bus.res_sel = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'd0;
            ea = pick(bus.fwd_a_sel, bus.rd1);
            eb = pick(bus.fwd_b_sel, bus.rd2);
            er = (bus.res_sel == 2'd3) ? 32'd0 : model_alu(ea, bus.alu_src ? bus.ext_imm : eb, bus.alu_ctr);
            #1;
            checks++; if (bus.ex_res !== er) begin failures++; $display("FAIL alu_rand ctr=%0d got=%h want=%h", bus.alu_ctr, bus.ex_res, er); end
            checks++; if (bus.fwd_b !== eb) begin failures++; $display("FAIL fwd_b_rand sel=%0d got=%h want=%h", bus.fwd_b_sel, bus.fwd_b, eb); end
        end
        idle_inputs();
    endtask

`ifdef EX_STAGE_MD_EN
    task automatic test_md_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int busy_n, cyc, stall_bad;
        model_md(op, a, b, ehi, elo);
        @(posedge clk); #1;
        bus.fwd_a_sel = '0; bus.fwd_b_sel = '0; bus.rd1 = a; bus.rd2 = b;
        bus.md_op = op; bus.res_sel = 2'd0; bus.md_start = 1'b1;
        @(posedge clk); #1;
        bus.md_start = 1'b0;
        busy_n = 0; cyc = 0; stall_bad = 0;
        while (bus.md_done !== 1'b1 && cyc < 100) begin
            if (bus.md_busy === 1'b1) busy_n++;
            if (bus.stall !== 1'b0) stall_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc >= 100) begin failures++; $display("FAIL md_timeout op=%0d got=no_done want=done", op); end
        checks++; if (busy_n != int'(W) + 1) begin failures++; $display("FAIL md_busy_cycles op=%0d got=%0d want=%0d", op, busy_n, W + 1); end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL md_idle_stall op=%0d got=%0d want=0", op, stall_bad); end
        bus.res_sel = 2'd2; #1;
        checks++; if (bus.ex_res !== elo) begin failures++; $display("FAIL md_lo op=%0d a=%h b=%h got=%h want=%h", op, a, b, bus.ex_res, elo); end
        bus.res_sel = 2'd1; #1;
        checks++; if (bus.ex_res !== ehi) begin failures++; $display("FAIL md_hi op=%0d a=%h b=%h got=%h want=%h", op, a, b, bus.ex_res, ehi); end
        bus.res_sel = 2'd0;
        @(posedge clk); #1;
        checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL md_done_pulse op=%0d got=%0b want=0", op, bus.md_done); end
    endtask

    task automatic test_muldiv_directed();
        test_md_op(2'd0, 32'hFFFF_FFFF, 32'd2);
        test_md_op(2'd3, 32'hFFFF_FFF9, 32'd2);
        test_md_op(2'd2, 32'd7, 32'd0);
        test_md_op(2'd3, 32'hFFFF_FFF9, 32'd0);
        test_md_op(2'd3, MINV, 32'hFFFF_FFFF);
        test_md_op(2'd1, MINV, MINV);
        test_md_op(2'd1, 32'hFFFF_FFFD, 32'd5);
        test_md_op(2'd3, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_muldiv_random();
        for (int i = 0; i < 16; i++)
            test_md_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    endtask

    task automatic test_stall_ignore();
        int busy_n, cyc, stall_bad;
        @(posedge clk); #1;
        bus.rd1 = 32'd100; bus.rd2 = 32'd7; bus.md_op = 2'd2; bus.res_sel = 2'd0; bus.md_start = 1'b1;
        @(posedge clk); #1;
        bus.rd1 = 32'd1000; bus.rd2 = 32'd3; bus.md_op = 2'd0; bus.res_sel = 2'd2;
        #1;
        busy_n = 0; cyc = 0; stall_bad = 0;
        while (bus.md_done !== 1'b1 && cyc < 100) begin
            if (bus.md_busy === 1'b1) busy_n++;
            if (bus.stall !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_at_done got=%0b want=0", bus.stall); end
        bus.md_start = 1'b0;
        checks++; if (cyc >= 100) begin failures++; $display("FAIL stall_timeout got=no_done want=done"); end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_while_busy got=%0d_low_cycles want=0", stall_bad); end
        checks++; if (busy_n != int'(W) + 1) begin failures++; $display("FAIL ignore_busy_cycles got=%0d want=%0d", busy_n, W + 1); end
        #1;
        checks++; if (bus.ex_res !== 32'd14) begin failures++; $display("FAIL ignore_lo got=%h want=0000000e", bus.ex_res); end
        bus.res_sel = 2'd1; #1;
        checks++; if (bus.ex_res !== 32'd2) begin failures++; $display("FAIL ignore_hi got=%h want=00000002", bus.ex_res); end
        bus.res_sel = 2'd0;
        @(posedge clk); #1;
        checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL ignore_relaunch got=%0b want=0", bus.md_busy); end
    endtask

    task automatic test_reset_mid();
        int done_n, busy_n, cyc;
        @(posedge clk); #1;
        bus.rd1 = 32'hFFFF_FFFD; bus.rd2 = 32'd5; bus.md_op = 2'd1; bus.md_start = 1'b1;
        @(posedge clk); #1;
        bus.md_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.md_start = 1'b1; bus.res_sel = 2'd1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b want=0", bus.md_busy); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%0b want=0", bus.stall); end
        checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b want=0", bus.md_done); end
        checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h want=0", bus.ex_res); end
        bus.res_sel = 2'd2; #1;
        checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h want=0", bus.ex_res); end
        bus.md_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.md_done !== 1'b0) done_n++;
            if (bus.md_busy !== 1'b0) busy_n++;
        end
        checks++; if (done_n != 0) begin failures++; $display("FAIL midrst_late_done got=%0d want=0", done_n); end
        checks++; if (busy_n != 0) begin failures++; $display("FAIL midrst_late_busy got=%0d want=0", busy_n); end
        checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL midrst_lo_after got=%h want=0", bus.ex_res); end
        // Launch held across reset release: accepted at the first edge afterwards
        rst_n = 1'b0;
        bus.rd1 = 32'd6; bus.rd2 = 32'd7; bus.md_op = 2'd0; bus.md_start = 1'b1; bus.res_sel = 2'd0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.md_start = 1'b0;
        checks++; if (bus.md_busy !== 1'b1) begin failures++; $display("FAIL first_start got=%0b want=1", bus.md_busy); end
        cyc = 0;
        while (bus.md_done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        bus.res_sel = 2'd2; #1;
        checks++; if (bus.ex_res !== 32'd42) begin failures++; $display("FAIL first_start_lo got=%h want=0000002a", bus.ex_res); end
        bus.res_sel = 2'd0;
    endtask
`else
    task automatic test_disabled();
        bus.rd1 = 32'd3; bus.rd2 = 32'd4; bus.alu_ctr = 4'd0;
        bus.md_start = 1'b1; bus.md_op = 2'd1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.res_sel = (i % 2 == 0) ? 2'd1 : 2'd2;
            #1;
            checks++; if (bus.ex_res !== 32'd0) begin failures++; $display("FAIL nomd_res sel=%0d got=%h want=0", bus.res_sel, bus.ex_res); end
            checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nomd_stall got=%0b want=0", bus.stall); end
            checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL nomd_busy got=%0b want=0", bus.md_busy); end
            checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL nomd_done got=%0b want=0", bus.md_done); end
        end
        bus.res_sel = 2'd0; #1;
        checks++; if (bus.ex_res !== 32'd7) begin failures++; $display("FAIL nomd_alu got=%h want=7", bus.ex_res); end
        bus.md_start = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fwd_alu();
`ifdef EX_STAGE_MD_EN
        test_muldiv_directed();
        test_muldiv_random();
        test_stall_ignore();
        test_reset_mid();
`else
        test_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
EX_STAGE_MD -- requirements
Module: ex_stage_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, even.
REQ-002 Parameter FWD_SRCS, default 5, number of forwarding sources on fwd_bus.
REQ-003 Parameter SELW, default 3, forwarding-select width; SHALL satisfy 2^SELW > FWD_SRCS.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rd1, rd2, ext_imm  in  WIDTH each  register-file operands and extended immediate.
REQ-008 fwd_bus  in  WIDTH*FWD_SRCS  forwarding sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-009 fwd_a_sel, fwd_b_sel  in  SELW each  operand-select codes.
REQ-010 alu_src  in  1  1 selects ext_imm as ALU B.
REQ-011 alu_ctr  in  4  ALU operation code.
REQ-012 res_sel  in  2  result source: 0 ALU, 1 HI, 2 LO, 3 zero.
REQ-013 md_start  in  1  launch multiply/divide.
REQ-014 md_op  in  2  0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
REQ-015 ex_res  out  WIDTH  stage result.
REQ-016 fwd_b  out  WIDTH  forwarded B operand before immediate mux (store data).
REQ-017 md_busy  out  1  iterative unit active.
REQ-018 md_done  out  1  one-cycle pulse when HI/LO are updated.
REQ-019 stall  out  1  hold request to the upstream pipeline.

Function
REQ-020 Select code 0 SHALL pick rd1/rd2; code k (1..FWD_SRCS) SHALL pick fwd_bus source k-1; any other code SHALL give zero.
REQ-021 ALU B SHALL be ext_imm when alu_src=1, else fwd_b.
REQ-022 alu_ctr: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL B by A[log2(WIDTH)-1:0], 9 SRL, 10 SRA, 11 LUI (B << WIDTH/2); others give zero; ADD/SUB wrap modulo 2^WIDTH.
REQ-023 ALU path and ex_res SHALL be purely combinational, zero latency.
REQ-024 md_start sampled at a rising edge with md_busy=0 SHALL latch the forwarded A/B operands and md_op, and set md_busy the next cycle.
REQ-025 md_start while md_busy=1 SHALL be ignored; the running operation is not disturbed.
REQ-026 Unit SHALL iterate one bit per cycle on operand magnitudes: md_busy high exactly WIDTH+1 cycles for every md_op (WIDTH iterations plus one sign-fix cycle).
REQ-027 States: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE; HI/LO written at the FIX->IDLE edge, md_done high the cycle after that edge.
REQ-028 Multiply: {HI,LO} = full 2*WIDTH-bit product, signed for MULT.
REQ-029 Divide: LO = quotient, HI = remainder; DIV truncates toward zero, quotient sign = sign(A) XOR sign(B), remainder sign = sign(A).
REQ-030 Divide by zero: LO = all ones, HI = dividend A, same latency, no other flag.
REQ-031 DIV of most-negative by -1: LO = most-negative value, HI = 0.
REQ-032 res_sel 1/2 SHALL return current HI/LO register contents.
REQ-033 stall SHALL equal md_busy AND (md_start OR res_sel is 1 or 2); stall=0 in IDLE.
REQ-034 A read of HI/LO in the same cycle as md_done SHALL return the new values.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, md_busy=0, md_done=0, stall=0, HI=0, LO=0, iteration counter 0.
REQ-036 Reset asserted mid-operation SHALL abandon it; no HI/LO update after release.
REQ-037 First md_start is accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-038 Macro EX_STAGE_MD_EN defined: multiply/divide unit and HI/LO built as above.
REQ-039 Macro EX_STAGE_MD_EN undefined: unit and HI/LO omitted; md_busy, md_done, stall tied 0; res_sel 1/2 return zero; md_start and md_op ignored; ALU path unchanged.

Verification
REQ-040 WIDTH=32, fwd_a_sel=3, source 2=0x12345678, rd2=1, alu_ctr=0 -> ex_res=0x12345679 same cycle; fwd_a_sel=7 -> A=0.
REQ-041 MULTU 0xFFFFFFFF x 2 -> md_busy 33 cycles, HI=0x00000001, LO=0xFFFFFFFE, md_done one pulse.
REQ-042 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-043 md_start plus res_sel=2 during busy -> stall=1 until md_done cycle; second md_start ignored; LO reflects first operation only.
REQ-044 rst_n pulsed low at iteration 10 of MULT -> md_busy=0 immediately, HI=LO=0, no md_done.
REQ-045 Build without EX_STAGE_MD_EN, md_start=1, res_sel=1 -> ex_res=0, stall=0, md_busy=0.
